// File: rtl/timer_responder.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and a level interrupt.
// Four 16-bit registers in an 8-byte window at BASE; byte-lane writes commit once per strobe.
`timescale 1ns/1ps
module timer_responder #(
    parameter logic [15:0] BASE = 16'hFF00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ADDR,
    input  logic [15:0] DIN,
    input  logic        RDN,
    input  logic        WRN0,
    input  logic        WRN1,
    output logic [15:0] DOUT,
    output logic        DOUT_EN,
    output logic        INT
);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RELOAD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    logic [7:0]  prescale_q, prescale_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        en_q, en_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  psc_q, psc_d;
    logic        wr_prev_q;
    logic        wr_block_q;

    logic     hit;
    reg_sel_e reg_sel;
    logic     wr_lo, wr_hi, wr_any;
    logic     commit;
    logic     tick, expire;
    logic     unused_addr0;

    assign hit          = (ADDR[15:3] == BASE[15:3]);
    assign reg_sel      = reg_sel_e'(ADDR[2:1]);
    assign unused_addr0 = ADDR[0];
    assign wr_lo        = ~WRN0;
    assign wr_hi        = ~WRN1;
    assign wr_any       = wr_lo | wr_hi;
    // A strobe already low when reset releases must go high once before it may commit.
    assign commit       = hit & wr_any & ~wr_prev_q & ~wr_block_q;
    assign tick         = en_q & (psc_q == prescale_q);
    assign expire       = tick & (count_q == 16'h0000);

    // Read path is purely combinational and side-effect free.
    always_comb begin
        DOUT_EN = hit & ~RDN;
        DOUT    = 16'h0000;
        if (DOUT_EN) begin
            unique case (reg_sel)
                REG_CTRL:   DOUT = {prescale_q, 5'b0, auto_q, ie_q, en_q};
                REG_RELOAD: DOUT = reload_q;
                REG_COUNT:  DOUT = count_q;
                REG_STATUS: DOUT = {14'b0, ovr_q, exp_q};
            endcase
        end
    end

    assign INT = exp_q & ie_q;

    // NOTE: every next-state value gets a default first so no path through this block infers a latch.
    always_comb begin
        prescale_d = prescale_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        en_d       = en_q;
        reload_d   = reload_q;
        count_d    = count_q;
        exp_d      = exp_q;
        ovr_d      = ovr_q;
        psc_d      = psc_q;

        if (tick) begin
            if (count_q != 16'h0000)
                count_d = count_q - 16'd1;
            else if (auto_q)
                count_d = reload_q;
            else
                count_d = 16'h0000;
        end

        if (commit) begin
            unique case (reg_sel)
                REG_CTRL: begin
                    if (wr_hi) prescale_d = DIN[15:8];
                    if (wr_lo) {auto_d, ie_d, en_d} = DIN[2:0];
                end
                REG_RELOAD: begin
                    if (wr_hi) reload_d[15:8] = DIN[15:8];
                    if (wr_lo) reload_d[7:0]  = DIN[7:0];
                end
                REG_COUNT: begin
                    if (wr_hi) count_d[15:8] = DIN[15:8];
                    if (wr_lo) count_d[7:0]  = DIN[7:0];
                end
                REG_STATUS: begin
                    if (wr_lo && DIN[0]) exp_d = 1'b0;
                    if (wr_lo && DIN[1]) ovr_d = 1'b0;
                end
            endcase
        end

        // Expiry wins over a same-edge status clear or enable write.
        if (expire) begin
            exp_d = 1'b1;
            if (exp_q) ovr_d = 1'b1;
            if (!auto_q) en_d = 1'b0;
        end

        if (!en_d || (en_d && !en_q) || (commit && reg_sel == REG_COUNT) || tick)
            psc_d = 8'h00;
        else
            psc_d = psc_q + 8'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prescale_q <= 8'h00;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            en_q       <= 1'b0;
            reload_q   <= 16'h0000;
            count_q    <= 16'h0000;
            exp_q      <= 1'b0;
            ovr_q      <= 1'b0;
            psc_q      <= 8'h00;
            wr_prev_q  <= 1'b0;
            wr_block_q <= 1'b1;
        end else begin
            prescale_q <= prescale_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            en_q       <= en_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            exp_q      <= exp_d;
            ovr_q      <= ovr_d;
            psc_q      <= psc_d;
            wr_prev_q  <= wr_any;
            wr_block_q <= wr_block_q & wr_any;
        end
    end

endmodule

// File: tb/tb_timer_responder.sv
// Directed self-checking bench for timer_responder: bus decode, lane writes, expiry,
// status conflicts and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_timer_responder;

    localparam logic [15:0] BASE   = 16'hFF00;
    localparam logic [15:0] A_CTRL = BASE + 16'd0;
    localparam logic [15:0] A_REL  = BASE + 16'd2;
    localparam logic [15:0] A_CNT  = BASE + 16'd4;
    localparam logic [15:0] A_STAT = BASE + 16'd6;

    logic        CLK;
    logic        RESET;
    logic [15:0] ADDR;
    logic [15:0] DIN;
    logic        RDN;
    logic        WRN0;
    logic        WRN1;
    logic [15:0] DOUT;
    logic        DOUT_EN;
    logic        INT;

    int n_checks = 0;
    int n_fail   = 0;

    timer_responder #(.BASE(BASE)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .RDN(RDN),
        .WRN0(WRN0), .WRN1(WRN1), .DOUT(DOUT), .DOUT_EN(DOUT_EN), .INT(INT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] addr, output logic [15:0] data, output logic en);
        ADDR = addr;
        RDN  = 1'b0;
        #1;
        data = DOUT;
        en   = DOUT_EN;
        RDN  = 1'b1;
    endtask

    task automatic rchk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        logic        e;
        rd(addr, d, e);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic lo, input logic hi);
        @(negedge CLK);
        ADDR = addr;
        DIN  = data;
        WRN0 = ~lo;
        WRN1 = ~hi;
        @(negedge CLK);
        WRN0 = 1'b1;
        WRN1 = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        logic        e;

        RESET = 1'b1;
        ADDR  = 16'h0000;
        DIN   = 16'h0000;
        RDN   = 1'b1;
        WRN0  = 1'b1;
        WRN1  = 1'b1;

        // Reads during reset return reset values.
        #12;
        rchk("reset_ctrl", A_CTRL, 16'h0000);
        rchk("reset_count", A_CNT, 16'h0000);
        check("reset_int", {15'b0, INT}, 16'h0000);
        @(negedge CLK);
        RESET = 1'b0;

        // Read decode.
        wr(A_CNT, 16'h00A5, 1'b1, 1'b1);
        rd(BASE + 16'd4, d, e);
        check("rd_cnt_en", {15'b0, e}, 16'h0001);
        check("rd_cnt_data", d, 16'h00A5);
        rchk("rd_addr0_ignored", BASE + 16'd5, 16'h00A5);
        rd(BASE + 16'd8, d, e);
        check("rd_miss_en", {15'b0, e}, 16'h0000);
        check("rd_miss_data", d, 16'h0000);
        ADDR = A_CNT;
        #1;
        check("rdn_high_en", {15'b0, DOUT_EN}, 16'h0000);
        check("rdn_high_data", DOUT, 16'h0000);

        // High-lane write with a long strobe commits once.
        wr(A_REL, 16'h1234, 1'b1, 1'b1);
        rchk("reload_full", A_REL, 16'h1234);
        @(negedge CLK);
        ADDR = A_REL;
        DIN  = 16'hABCD;
        WRN1 = 1'b0;
        @(negedge CLK);
        DIN  = 16'h5678;
        repeat (4) @(negedge CLK);
        WRN1 = 1'b1;
        rchk("reload_hi_lane_once", A_REL, 16'hAB34);

        // Reset in the middle of a strobe: no commit until the strobe re-arms.
        @(negedge CLK);
        ADDR = A_CTRL;
        DIN  = 16'h0001;
        WRN0 = 1'b0;
        #1 RESET = 1'b1;
        #2 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        rchk("reset_midstrobe_no_commit", A_CTRL, 16'h0000);
        WRN0 = 1'b1;

        // One-shot: PRESCALE=2, COUNT=2 expires 9 cycles after enable.
        wr(A_CNT, 16'h0002, 1'b1, 1'b1);
        wr(A_CTRL, 16'h0201, 1'b1, 1'b1);
        rchk("oneshot_ctrl", A_CTRL, 16'h0201);
        repeat (3) @(negedge CLK);
        rchk("oneshot_cnt_c3", A_CNT, 16'h0001);
        repeat (5) @(negedge CLK);
        rchk("oneshot_cnt_c8", A_CNT, 16'h0000);
        rchk("oneshot_en_c8", A_CTRL, 16'h0201);
        rchk("oneshot_stat_c8", A_STAT, 16'h0000);
        @(negedge CLK);
        rchk("oneshot_en_cleared", A_CTRL, 16'h0200);
        rchk("oneshot_exp", A_STAT, 16'h0001);
        rchk("oneshot_cnt_c9", A_CNT, 16'h0000);
        check("oneshot_int_masked", {15'b0, INT}, 16'h0000);
        repeat (3) @(negedge CLK);
        rchk("oneshot_cnt_hold", A_CNT, 16'h0000);

        // Auto-reload: RELOAD=3, PRESCALE=0 gives an expiry every 4 cycles.
        wr(A_STAT, 16'h0003, 1'b1, 1'b0);
        rchk("stat_cleared", A_STAT, 16'h0000);
        wr(A_REL, 16'h0003, 1'b1, 1'b1);
        wr(A_CNT, 16'h0003, 1'b1, 1'b1);
        wr(A_CTRL, 16'h0007, 1'b1, 1'b1);
        rchk("auto_cnt_3", A_CNT, 16'h0003);
        @(negedge CLK);
        rchk("auto_cnt_2", A_CNT, 16'h0002);
        @(negedge CLK);
        rchk("auto_cnt_1", A_CNT, 16'h0001);
        @(negedge CLK);
        rchk("auto_cnt_0", A_CNT, 16'h0000);
        @(negedge CLK);
        rchk("auto_cnt_reload", A_CNT, 16'h0003);
        rchk("auto_exp1", A_STAT, 16'h0001);
        check("auto_int1", {15'b0, INT}, 16'h0001);
        ADDR = A_STAT;
        DIN  = 16'h0003;
        WRN0 = 1'b0;
        @(negedge CLK);
        WRN0 = 1'b1;
        rchk("auto_w1c", A_STAT, 16'h0000);
        check("auto_int_cleared", {15'b0, INT}, 16'h0000);
        @(negedge CLK);
        @(negedge CLK);
        rchk("auto_cnt_before_exp2", A_CNT, 16'h0000);
        // Clear lands on the same edge as the next expiry.
        ADDR = A_STAT;
        DIN  = 16'h0001;
        WRN0 = 1'b0;
        @(negedge CLK);
        WRN0 = 1'b1;
        rchk("exp_beats_clear", A_STAT, 16'h0001);
        rchk("auto_cnt_reload2", A_CNT, 16'h0003);
        repeat (4) @(negedge CLK);
        rchk("ovr_set", A_STAT, 16'h0003);
        check("auto_int2", {15'b0, INT}, 16'h0001);

        // Asynchronous reset while counting with INT high.
        @(negedge CLK);
        #1 RESET = 1'b1;
        #1;
        check("async_rst_int", {15'b0, INT}, 16'h0000);
        rchk("async_rst_ctrl", A_CTRL, 16'h0000);
        rchk("async_rst_count", A_CNT, 16'h0000);
        rchk("async_rst_reload", A_REL, 16'h0000);
        rchk("async_rst_status", A_STAT, 16'h0000);
        @(negedge CLK);
        RESET = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
